// File: rtl/rle_board_loader.sv
// Expands an RLE byte stream (bit7 = value, bits6:0 = N -> N+1 cells) into a
// cell-at-a-time board stream. Short downloads are padded with zeros and long ones are truncated.
module rle_board_loader #(
  parameter int BOARD_PIXELS = 2073600
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  output logic        pix_valid,
  output logic        pix_data,
  input  logic        pix_ready,
  output logic [21:0] pix_count,
  output logic        load_done,
  output logic        overflow
);
  localparam logic [21:0] BP = 22'(BOARD_PIXELS);

  typedef enum logic [1:0] {IDLE, RUN, PAD, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  run_rem_q, run_rem_d;
  logic        run_val_q, run_val_d;
  logic [21:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        act_prev_q;
  logic        rise, full, accept;

  always_comb begin
    rise      = dl_active & ~act_prev_q;
    full      = (cnt_q >= BP);
    state_d   = state_q;
    run_rem_d = run_rem_q;
    run_val_d = run_val_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    accept    = 1'b0;
    dl_wait   = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 1'b0;
    load_done = 1'b0;
    case (state_q)
      IDLE: ;
      RUN: begin
        accept  = dl_wr & dl_active & (run_rem_q == 8'd0);
        dl_wait = accept | (run_rem_q != 8'd0);
        if (run_rem_q != 8'd0) begin
          // Board already full: burn the excess cells at one per cycle.
          if (full) begin
            run_rem_d = run_rem_q - 8'd1;
            ovf_d     = 1'b1;
          end else begin
            pix_valid = 1'b1;
            pix_data  = run_val_q;
            if (pix_ready) begin
              run_rem_d = run_rem_q - 8'd1;
              cnt_d     = cnt_q + 22'd1;
            end
          end
        end else if (accept) begin
          run_val_d = dl_data[7];
          run_rem_d = {1'b0, dl_data[6:0]} + 8'd1;
        end else if (!dl_active) begin
          state_d = full ? DONE : PAD;
        end
      end
      PAD: begin
        if (full) state_d = DONE;
        else begin
          pix_valid = 1'b1;
          if (pix_ready) cnt_d = cnt_q + 22'd1;
        end
      end
      DONE: begin
        load_done = ~rise;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new download restarts the load from any state but RUN.
    if (rise && state_q != RUN) begin
      state_d   = RUN;
      run_rem_d = 8'd0;
      cnt_d     = 22'd0;
      ovf_d     = 1'b0;
    end
    if (reset) begin
      dl_wait   = 1'b0;
      pix_valid = 1'b0;
      pix_data  = 1'b0;
      load_done = 1'b0;
    end
  end

  // act_prev resets high so a download already active at reset release is not a start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      run_rem_q  <= 8'd0;
      run_val_q  <= 1'b0;
      cnt_q      <= 22'd0;
      ovf_q      <= 1'b0;
      act_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      run_rem_q  <= run_rem_d;
      run_val_q  <= run_val_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      act_prev_q <= dl_active;
    end
  end

  assign pix_count = cnt_q;
  assign overflow  = ovf_q;
endmodule
